// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-cycle instruction fetch stage.
// On an accepted start it latches pc into imem_addr. It then holds imem_req until
// ack, timeout or flush. An acked word is captured into ir, and its address into ir_pc.
// Optional feature: define ADDR_CHECK_EN to reject a misaligned pc (pc[1:0] != 0).
// A rejected fetch goes straight to ERR and never raises imem_req.
// Ports:
//   clk, rst (async, active-low)
//   start, flush, pc                        -- controller side
//   imem_req, imem_addr, imem_ack, imem_rdata -- instruction memory side
//   ir, ir_pc                               -- instruction register and its address
//   busy, done, err                         -- status (done/err are 1-cycle pulses)
module instr_fetch_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TMO_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_e;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              req_q, busy_q, done_q, err_q;
  logic              misaligned;

`ifdef ADDR_CHECK_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = pc;
          cnt_d   = '0;
          state_d = misaligned ? ERR : REQ;
        end
      end
      REQ: begin
        // Flush wins over a same-cycle ack; that data is dropped
        if (flush) begin
          state_d = IDLE;
        end else if (imem_ack) begin
          ir_d    = imem_rdata;
          ir_pc_d = addr_q;
          state_d = DONE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and status registers; status flops decode the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ir_q    <= '0;
      ir_pc_q <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      req_q   <= (state_d == REQ);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      err_q   <= (state_d == ERR);
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned TMO_W   = 4;
`ifdef ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start, flush, imem_ack;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_req, busy, done, err;
  logic [ADDR_W-1:0] imem_addr, ir_pc;
  logic [DATA_W-1:0] ir;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .ir_pc(ir_pc),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an outstanding fetch ages one cycle per clock until
  // it is acked, flushed or runs out of patience; completion shows as a pulse.
  bit              m_out;
  int              m_age;
  bit              m_done, m_err;
  logic [ADDR_W-1:0] m_addr, m_ir_pc;
  logic [DATA_W-1:0] m_ir;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_out = 0; m_age = 0; m_done = 0; m_err = 0;
      m_addr = '0; m_ir = '0; m_ir_pc = '0;
    end else begin
      bit pulse_cycle;
      pulse_cycle = m_done || m_err;
      m_done = 0; m_err = 0;
      if (m_out) begin
        if (flush) m_out = 0;
        else if (imem_ack) begin
          m_ir = imem_rdata; m_ir_pc = m_addr; m_out = 0; m_done = 1;
        end else begin
          m_age++;
          if (m_age == int'(TIMEOUT)) begin m_out = 0; m_err = 1; end
        end
      end else if (!pulse_cycle && start) begin
        m_addr = pc; m_age = 0;
        if (CHK && pc[1:0] != 2'b00) m_err = 1;
        else m_out = 1;
      end
    end
    #1;
    chk("imem_req",  64'(imem_req),  64'(m_out));
    chk("busy",      64'(busy),      64'(m_out || m_done || m_err));
    chk("done",      64'(done),      64'(m_done));
    chk("err",       64'(err),       64'(m_err));
    chk("imem_addr", 64'(imem_addr), 64'(m_addr));
    chk("ir",        64'(ir),        64'(m_ir));
    chk("ir_pc",     64'(ir_pc),     64'(m_ir_pc));
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 0; flush = 0; imem_ack = 1'b1; pc = '0; imem_rdata = 32'hFFFF_FFFF;
    repeat (3) cyc();
    // Reset holds everything at zero even with ack asserted
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ir", 64'(ir), 64'd0);
    rst = 1'b1;
    repeat (2) cyc();
    chk("post_rst_req", 64'(imem_req), 64'd0);
    imem_ack = 0;

    // Basic fetch, ack on first REQ cycle
    pc = 32'h0000_3000; start = 1; cyc();
    start = 0;
    chk("basic_req", 64'(imem_req), 64'd1);
    chk("basic_addr", 64'(imem_addr), 64'h3000);
    imem_ack = 1; imem_rdata = 32'h2008_0005; cyc();
    imem_ack = 0;
    chk("basic_done", 64'(done), 64'd1);
    chk("basic_ir", 64'(ir), 64'h2008_0005);
    chk("basic_ir_pc", 64'(ir_pc), 64'h3000);
    cyc();

    // Wait states: ack on third REQ cycle, start pulses while busy ignored
    pc = 32'h0000_4000; start = 1; cyc();
    n = 0;
    for (int i = 0; i < 3; i++) begin
      n += int'(imem_req);
      pc = 32'h0000_5000; start = 1;
      if (i == 2) imem_ack = 1;
      cyc();
    end
    imem_ack = 0;
    chk("ws_req_cycles", 64'(n), 64'd3);
    chk("ws_done", 64'(done), 64'd1);
    chk("ws_addr_stable", 64'(imem_addr), 64'h4000);
    chk("ws_ir_pc", 64'(ir_pc), 64'h4000);
    cyc();
    start = 0;
    chk("ws_start_in_done_ignored", 64'(busy), 64'd0);
    cyc();

    // Timeout: never ack
    pc = 32'h0000_6000; start = 1; cyc();
    start = 0; n = 0;
    for (int i = 0; i < 40 && !err; i++) begin
      n += int'(imem_req);
      cyc();
    end
    chk("tmo_req_cycles", 64'(n), 64'd15);
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_ir_kept", 64'(ir), 64'h2008_0005);
    cyc();
    chk("tmo_err_pulse", 64'(err), 64'd0);

    // Flush with same-cycle ack
    pc = 32'h0000_7000; start = 1; cyc();
    start = 0; flush = 1; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; cyc();
    flush = 0; imem_ack = 0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_no_done", 64'(done), 64'd0);
    chk("flush_no_err", 64'(err), 64'd0);
    chk("flush_ir_kept", 64'(ir), 64'h2008_0005);
    pc = 32'h0000_8000; start = 1; cyc();
    start = 0; imem_ack = 1; imem_rdata = 32'hCAFE_F00D; cyc();
    imem_ack = 0;
    chk("refetch_ir", 64'(ir), 64'hCAFE_F00D);
    cyc();

    // Misaligned pc
    pc = 32'h0000_3002; start = 1; cyc();
    start = 0;
    chk("mis_addr", 64'(imem_addr), 64'h3002);
    if (CHK) begin
      chk("mis_err", 64'(err), 64'd1);
      chk("mis_no_req", 64'(imem_req), 64'd0);
      chk("mis_ir_kept", 64'(ir), 64'hCAFE_F00D);
    end else begin
      chk("mis_req", 64'(imem_req), 64'd1);
      imem_ack = 1; imem_rdata = 32'h1234_5678; cyc();
      imem_ack = 0;
      chk("mis_done", 64'(done), 64'd1);
      chk("mis_ir_pc", 64'(ir_pc), 64'h3002);
    end
    cyc();

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(3) == 0);
      flush      = ($urandom_range(15) == 0);
      imem_ack   = ($urandom_range(4) == 0);
      pc         = $urandom;
      imem_rdata = $urandom;
      cyc();
    end
    start = 0; flush = 0; imem_ack = 0;
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
